// File: rtl/pi_compensator_if.sv
// Sample/command bus between the ADC read stage, the PI compensator and the PWM generator.
// master drives error samples and loop enable; slave returns the duty command and status flags.
interface pi_compensator_if #(
  parameter int ERR_W  = 13,
  parameter int DUTY_W = 10
);
  logic                    enable;
  logic                    err_valid;
  logic [1:0]              ch_id;
  logic signed [ERR_W-1:0] err;
  logic [DUTY_W-1:0]       duty;
  logic                    duty_valid;
  logic                    busy;
  logic                    overrun;
  logic                    sat_hi;
  logic                    sat_lo;

  modport master (
    output enable, err_valid, ch_id, err,
    input  duty, duty_valid, busy, overrun, sat_hi, sat_lo
  );

  modport slave (
    input  enable, err_valid, ch_id, err,
    output duty, duty_valid, busy, overrun, sat_hi, sat_lo
  );
endinterface

// File: rtl/pi_compensator.sv
// PI compensator: error sample -> saturated duty command, one shared multiplier, 5-edge latency.
// Define PI_ANTIWINDUP_EN to clamp the integrator to +/-I_LIM and hold it while the output is saturated.
//
// state | meaning
// IDLE  | waiting for a captured sample; ENABLE low clears integrator, duty and flags
// MUL_P | P = KP * E_REG
// MUL_I | I_ACC = sat(I_ACC + KI * E_REG)
// SUM   | T = ((P + I_ACC) >>> SHIFT) + DUTY_BIAS
// SAT   | DUTY = clamp(T), SAT flags, one-cycle DUTY_VALID
module pi_compensator #(
  parameter logic [1:0] SEL_CH    = 2'b00,
  parameter int         ERR_W     = 13,
  parameter int         KP        = 4,
  parameter int         KI        = 1,
  parameter int         SHIFT     = 4,
  parameter int         ACC_W     = 24,
  parameter int         DUTY_W    = 10,
  parameter int         DUTY_BIAS = 512,
  parameter int         DUTY_MIN  = 32,
  parameter int         DUTY_MAX  = 960,
  parameter int         I_LIM     = 8192
) (
  input logic              clk,
  input logic              rstp,
  pi_compensator_if.slave  bus
);

`ifdef PI_ANTIWINDUP_EN
  localparam bit AW_EN = 1'b1;
`else
  localparam bit AW_EN = 1'b0;
`endif

  localparam logic signed [ACC_W:0] I_HI = AW_EN ? (ACC_W+1)'(I_LIM)  : (ACC_W+1)'(2**(ACC_W-1) - 1);
  localparam logic signed [ACC_W:0] I_LO = AW_EN ? (ACC_W+1)'(-I_LIM) : (ACC_W+1)'(-(2**(ACC_W-1)));

  typedef enum logic [2:0] {IDLE, MUL_P, MUL_I, SUM, SAT} state_t;
  state_t state, state_nxt;

  logic                    cap_vld;
  logic signed [ERR_W-1:0] e_reg;
  logic signed [ACC_W-1:0] p_reg;
  logic signed [ACC_W-1:0] i_acc;
  logic signed [ACC_W+1:0] t_reg;
  logic [DUTY_W-1:0]       duty_r;
  logic                    duty_valid_r, overrun_r, sat_hi_r, sat_lo_r;

  logic                    busy, match, take, hold;
  logic signed [ACC_W-1:0] gain, e_ext, prod, i_next;
  logic signed [ACC_W:0]   i_sum, s_sum;
  logic signed [ACC_W+1:0] t_next;

  assign match = bus.err_valid && (bus.ch_id == SEL_CH);
  // Samples are registered one edge before the FSM leaves IDLE, giving the k+5 output latency.
  assign take  = match && bus.enable && (state == IDLE) && !cap_vld;

  always_ff @(posedge clk) begin
    if (rstp) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cap_vld) state_nxt = MUL_P;
      MUL_P:   state_nxt = MUL_I;
      MUL_I:   state_nxt = SUM;
      SUM:     state_nxt = SAT;
      SAT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    gain = (state == MUL_I) ? ACC_W'(KI) : ACC_W'(KP);
  end

  assign e_ext  = ACC_W'(e_reg);
  assign prod   = e_ext * gain;
  assign i_sum  = (ACC_W+1)'(i_acc) + (ACC_W+1)'(prod);
  assign hold   = AW_EN && ((sat_hi_r && e_reg > 0) || (sat_lo_r && e_reg < 0));
  assign s_sum  = (ACC_W+1)'(p_reg) + (ACC_W+1)'(i_acc);
  assign t_next = (ACC_W+2)'(s_sum >>> SHIFT) + (ACC_W+2)'(DUTY_BIAS);

  always_comb begin
    i_next = i_sum[ACC_W-1:0];
    if (i_sum > I_HI)      i_next = I_HI[ACC_W-1:0];
    else if (i_sum < I_LO) i_next = I_LO[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      cap_vld      <= 1'b0;
      e_reg        <= '0;
      p_reg        <= '0;
      i_acc        <= '0;
      t_reg        <= '0;
      duty_r       <= DUTY_W'(DUTY_MIN);
      duty_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
      sat_hi_r     <= 1'b0;
      sat_lo_r     <= 1'b0;
    end else begin
      duty_valid_r <= 1'b0;
      cap_vld      <= take;
      if (take) e_reg <= bus.err;
      // A pending capture counts as busy, so SAT's exit edge also drops a new sample.
      if (match && (busy || cap_vld)) overrun_r <= 1'b1;
      case (state)
        IDLE: begin
          if (!bus.enable && !cap_vld) begin
            i_acc    <= '0;
            duty_r   <= DUTY_W'(DUTY_MIN);
            sat_hi_r <= 1'b0;
            sat_lo_r <= 1'b0;
          end
        end
        MUL_P: p_reg <= prod;
        MUL_I: if (!hold) i_acc <= i_next;
        SUM:   t_reg <= t_next;
        SAT: begin
          duty_valid_r <= 1'b1;
          sat_hi_r     <= (t_reg > (ACC_W+2)'(DUTY_MAX));
          sat_lo_r     <= (t_reg < (ACC_W+2)'(DUTY_MIN));
          if (t_reg > (ACC_W+2)'(DUTY_MAX))      duty_r <= DUTY_W'(DUTY_MAX);
          else if (t_reg < (ACC_W+2)'(DUTY_MIN)) duty_r <= DUTY_W'(DUTY_MIN);
          else                                   duty_r <= t_reg[DUTY_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.duty       = duty_r;
  assign bus.duty_valid = duty_valid_r;
  assign bus.busy       = busy;
  assign bus.overrun    = overrun_r;
  assign bus.sat_hi     = sat_hi_r;
  assign bus.sat_lo     = sat_lo_r;

endmodule

// File: tb/tb_pi_compensator.sv
// Scoreboard bench for pi_compensator: stimulus pushes expected duty commands, a monitor pops them.
module tb_pi_compensator;
  localparam int  KP = 4, KI = 1, SHIFT = 4, BIAS = 512, DMIN = 32, DMAX = 960;
  localparam longint ACC_MAX = 64'sd8388607;

  typedef struct {
    longint duty;
    bit     hi;
    bit     lo;
    int     edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic rstp;
  always #25 clk = ~clk;

  pi_compensator_if #(.ERR_W(13), .DUTY_W(10)) bus ();
  pi_compensator dut (.clk(clk), .rstp(rstp), .bus(bus.slave));

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     checks = 0, failures = 0;
  int     edge_n = 0, next_free = 0;
  longint m_i = 0, m_duty = DMIN;
  bit     m_hi = 0, m_lo = 0, m_ovr = 0, m_en = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  // Reference PI law in plain integer arithmetic.
  function automatic void model_sample(input longint e, input int at_edge);
    longint p, ni, t, lim_hi, lim_lo;
    bit hold;
    exp_t x;
    p = KP * e;
`ifdef PI_ANTIWINDUP_EN
    lim_hi = 8192;
    lim_lo = -8192;
    hold = (m_hi && e > 0) || (m_lo && e < 0);
`else
    lim_hi = ACC_MAX;
    lim_lo = -ACC_MAX - 1;
    hold = 1'b0;
`endif
    if (!hold) begin
      ni = m_i + KI * e;
      if (ni > lim_hi) ni = lim_hi;
      if (ni < lim_lo) ni = lim_lo;
      m_i = ni;
    end
    t = ((p + m_i) >>> SHIFT) + BIAS;
    m_hi = (t > DMAX);
    m_lo = (t < DMIN);
    m_duty = m_hi ? DMAX : (m_lo ? DMIN : t);
    x.duty = m_duty; x.hi = m_hi; x.lo = m_lo; x.edge_no = at_edge;
    exp_q.push_back(x);
  endfunction

  task automatic send(input logic [1:0] ch, input int e);
    bus.err_valid = 1'b1;
    bus.ch_id     = ch;
    bus.err       = 13'(e);
    tick();
    bus.err_valid = 1'b0;
    if (ch == 2'd0) begin
      if (edge_n < next_free) m_ovr = 1'b1;
      else if (m_en) begin
        model_sample(longint'(e), edge_n + 5);
        next_free = edge_n + 6;
      end
    end
  endtask

  task automatic wait_idle();
    while (edge_n < next_free) tick();
  endtask

  task automatic set_enable(input bit v);
    bus.enable = v;
    m_en = v;
    if (!v) begin
      wait_idle();
      tick();
      tick();
      m_i = 0; m_hi = 0; m_lo = 0; m_duty = DMIN;
      check("en_off_duty", longint'(bus.duty), DMIN);
      check("en_off_sat", longint'({bus.sat_hi, bus.sat_lo}), 0);
    end
  endtask

  always @(negedge clk) begin
    if (bus.duty_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_duty_valid actual=1 expected=0 duty=%0d (edge %0d)", bus.duty, edge_n);
      end else begin
        mon_e = exp_q.pop_front();
        check("duty", longint'(bus.duty), mon_e.duty);
        check("sat_hi", longint'(bus.sat_hi), longint'(mon_e.hi));
        check("sat_lo", longint'(bus.sat_lo), longint'(mon_e.lo));
        check("latency_edge", longint'(edge_n), longint'(mon_e.edge_no));
      end
    end
  end

  initial begin
    #(50 * 60000);
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.enable = 1'b0; bus.err_valid = 1'b0; bus.ch_id = 2'd0; bus.err = '0;
    rstp = 1'b1;
    repeat (3) tick();
    check("rst_duty", longint'(bus.duty), DMIN);
    check("rst_valid", longint'(bus.duty_valid), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_overrun", longint'(bus.overrun), 0);
    check("rst_sat", longint'({bus.sat_hi, bus.sat_lo}), 0);
    rstp = 1'b0;
    tick();

    // step response and hold with zero error
    set_enable(1'b1);
    send(2'd0, 16);
    tick();
    check("busy_in_compute", longint'(bus.busy), 1);
    wait_idle();
    check("step_duty", longint'(bus.duty), 517);
    send(2'd0, 0);
    wait_idle();
    check("zero_err_duty", longint'(bus.duty), 513);

    set_enable(1'b0);
    set_enable(1'b1);
    send(2'd0, 0);
    wait_idle();
    check("reenable_duty", longint'(bus.duty), 512);

    // other channel ignored, then back-to-back overrun
    send(2'd1, 100);
    check("other_ch_busy", longint'(bus.busy), 0);
    tick();
    check("other_ch_duty", longint'(bus.duty), m_duty);
    check("no_overrun_yet", longint'(bus.overrun), 0);
    send(2'd0, 16);
    tick();
    send(2'd0, 16);
    check("overrun_set", longint'(bus.overrun), longint'(m_ovr));
    wait_idle();

    // negative saturation and recovery
    set_enable(1'b0);
    set_enable(1'b1);
    repeat (10) begin
      send(2'd0, -4096);
      wait_idle();
    end
    check("sat_lo_duty", longint'(bus.duty), DMIN);
    check("sat_lo_flag", longint'(bus.sat_lo), 1);
    send(2'd0, 16);
    wait_idle();
    check("sat_recover_duty", longint'(bus.duty), m_duty);

    // reset while in MUL_I aborts the sample
    send(2'd0, 16);
    tick();
    tick();
    rstp = 1'b1;
    tick();
    rstp = 1'b0;
    void'(exp_q.pop_back());
    m_i = 0; m_hi = 0; m_lo = 0; m_ovr = 0; m_duty = DMIN; next_free = edge_n;
    repeat (6) tick();
    check("midrst_overrun", longint'(bus.overrun), 0);
    check("midrst_duty", longint'(bus.duty), DMIN);
    send(2'd0, 16);
    wait_idle();
    check("midrst_step_duty", longint'(bus.duty), 517);

    // randomized traffic with random gaps and channels
    for (int n = 0; n < 150; n++) begin
      logic [1:0] ch;
      int e;
      ch = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      e = ($urandom_range(0, 3) == 0) ? (int'($urandom_range(0, 8191)) - 4096)
                                       : (int'($urandom_range(0, 400)) - 200);
      send(ch, e);
      repeat ($urandom_range(0, 7)) tick();
    end
    wait_idle();
    repeat (2) tick();
    check("rand_overrun", longint'(bus.overrun), longint'(m_ovr));
    check("final_duty", longint'(bus.duty), m_duty);
    check("queue_drained", longint'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
